// File: rtl/vga_sync_decoder_if.sv
// Bus bundle between a VGA timing source and the sync decoder.
// The master side drives the raw sync samples and the error-clear strobe;
// the slave side (the decoder) returns the recovered position and status.
interface vga_sync_decoder_if;
    logic       pix_en;
    logic       hs;
    logic       vs;
    logic       err_clr;
    logic [8:0] row_addr;
    logic [9:0] col_addr;
    logic       active;
    logic       locked;
    logic       frame_start;
    logic [7:0] frame_cnt;
    logic       err_h;
    logic       err_v;

    modport master (
        output pix_en, hs, vs, err_clr,
        input  row_addr, col_addr, active, locked, frame_start, frame_cnt, err_h, err_v
    );

    modport slave (
        input  pix_en, hs, vs, err_clr,
        output row_addr, col_addr, active, locked, frame_start, frame_cnt, err_h, err_v
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA sync decoder: recovers pixel position from active-low hs/vs samples,
// locks onto a stable line/frame cadence and flags timing violations.
// The visible window size is parameterised so small timings can be used
// without touching the logic; defaults give the standard 640x480 mode.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_VIS_START = 144,
    parameter int H_VIS       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_VIS_START = 35,
    parameter int V_VIS       = 480
) (
    input  logic               CLK,
    input  logic               RST,
    vga_sync_decoder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_TRACK,
        ST_LOCKED
    } state_t;

    localparam logic [9:0]  LP_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  LP_H_TOTAL  = 10'(H_TOTAL);
    localparam logic [9:0]  LP_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  LP_V_TOTAL  = 10'(V_TOTAL);
    localparam logic [9:0]  LP_H_OFF    = 10'(H_VIS_START);
    localparam logic [9:0]  LP_V_OFF    = 10'(V_VIS_START);
    localparam logic [10:0] LP_H_VIS_LO = 11'(H_VIS_START);
    localparam logic [10:0] LP_H_VIS_HI = 11'(H_VIS_START + H_VIS);
    localparam logic [10:0] LP_V_VIS_LO = 11'(V_VIS_START);
    localparam logic [10:0] LP_V_VIS_HI = 11'(V_VIS_START + V_VIS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_hcnt;
    logic [9:0] w_hcnt_nxt;
    logic [9:0] r_vcnt;
    logic [9:0] w_vcnt_nxt;
    logic       r_hs_prev;
    logic       r_vs_prev;
    logic       r_line_ok;
    logic       w_line_ok_nxt;

    logic       w_sample;
    logic       w_hfall;
    logic       w_vfall;
    logic       w_h_at_end;
    logic       w_v_at_end;
    logic       w_hviol;
    logic       w_vviol;
    logic       w_accept;
    logic       w_set_h;
    logic       w_set_v;

    logic       w_locked_nxt;
    logic       w_in_h;
    logic       w_in_v;
    logic       w_active_nxt;
    logic [9:0] w_col_nxt;
    logic [8:0] w_row_nxt;

    logic       r_locked;
    logic       r_active;
    logic [9:0] r_col_addr;
    logic [8:0] r_row_addr;
    logic       r_frame_start;
    logic [7:0] r_frame_cnt;
    logic       r_err_h;
    logic       r_err_v;

    // Edge detection and counter next-values. vs_prev holds the vs level seen
    // at the previous hs fall, so a vs fall is only ever seen at a line start.
    always_comb begin
        w_sample = bus.pix_en;
        w_hfall  = w_sample & r_hs_prev & ~bus.hs;
        w_vfall  = w_hfall & r_vs_prev & ~bus.vs;

        w_hcnt_nxt = r_hcnt;
        if (w_hfall) begin
            w_hcnt_nxt = 10'd0;
        end else if (w_sample && (r_hcnt != 10'h3FF)) begin
            w_hcnt_nxt = r_hcnt + 10'd1;
        end

        w_vcnt_nxt = r_vcnt;
        if (w_vfall) begin
            w_vcnt_nxt = 10'd0;
        end else if (w_hfall && (r_vcnt != 10'h3FF)) begin
            w_vcnt_nxt = r_vcnt + 10'd1;
        end

        w_h_at_end = (r_hcnt == LP_H_LAST);
        w_v_at_end = (r_vcnt == LP_V_LAST);
        w_hviol    = w_hfall ? !w_h_at_end : (w_sample && (w_hcnt_nxt == LP_H_TOTAL));
        w_vviol    = w_vfall ? !w_v_at_end : (w_hfall && (w_vcnt_nxt == LP_V_TOTAL));
    end

    // Lock state machine: TRACK must see one clean frame before LOCKED; only
    // LOCKED reports violations, TRACK just falls back to SEARCH quietly.
    always_comb begin
        w_state_nxt   = r_state;
        w_line_ok_nxt = r_line_ok;
        w_accept      = 1'b0;
        w_set_h       = 1'b0;
        w_set_v       = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vfall) begin
                    w_state_nxt   = ST_TRACK;
                    w_line_ok_nxt = 1'b1;
                end
            end
            ST_TRACK: begin
                if (w_vfall) begin
                    if (r_line_ok && w_h_at_end && w_v_at_end) begin
                        w_state_nxt = ST_LOCKED;
                        w_accept    = 1'b1;
                    end else begin
                        w_state_nxt = ST_SEARCH;
                    end
                end else if (w_hfall && !w_h_at_end) begin
                    w_line_ok_nxt = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (w_hviol || w_vviol) begin
                    w_state_nxt = ST_SEARCH;
                    w_set_h     = w_hviol;
                    w_set_v     = w_vviol;
                end else if (w_vfall) begin
                    w_accept = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // Output decode from the post-sample position so outputs land one CLK
    // after the sample that decides them.
    always_comb begin
        w_locked_nxt = (w_state_nxt == ST_LOCKED);
        w_in_h       = ({1'b0, w_hcnt_nxt} >= LP_H_VIS_LO) && ({1'b0, w_hcnt_nxt} < LP_H_VIS_HI);
        w_in_v       = ({1'b0, w_vcnt_nxt} >= LP_V_VIS_LO) && ({1'b0, w_vcnt_nxt} < LP_V_VIS_HI);
        w_active_nxt = w_locked_nxt && w_in_h && w_in_v;
        w_col_nxt    = 10'd0;
        w_row_nxt    = 9'd0;
        if (w_active_nxt) begin
            w_col_nxt = 10'(w_hcnt_nxt - LP_H_OFF);
            w_row_nxt = 9'(w_vcnt_nxt - LP_V_OFF);
        end
    end

    // Sample-qualified state: everything here advances only on pix_en.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_SEARCH;
            r_hcnt     <= 10'd0;
            r_vcnt     <= 10'd0;
            r_hs_prev  <= 1'b1;
            r_vs_prev  <= 1'b1;
            r_line_ok  <= 1'b0;
            r_locked   <= 1'b0;
            r_active   <= 1'b0;
            r_col_addr <= 10'd0;
            r_row_addr <= 9'd0;
        end else if (w_sample) begin
            r_state    <= w_state_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_vcnt     <= w_vcnt_nxt;
            r_hs_prev  <= bus.hs;
            r_line_ok  <= w_line_ok_nxt;
            r_locked   <= w_locked_nxt;
            r_active   <= w_active_nxt;
            r_col_addr <= w_col_nxt;
            r_row_addr <= w_row_nxt;
            if (w_hfall) begin
                r_vs_prev <= bus.vs;
            end
        end
    end

    // Frame pulse/counter and sticky error flags; a fresh violation beats a
    // simultaneous clear, and the clear itself acts on any CLK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_start <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_err_h       <= 1'b0;
            r_err_v       <= 1'b0;
        end else begin
            r_frame_start <= w_accept;
            if (w_accept) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (w_set_h) begin
                r_err_h <= 1'b1;
            end else if (bus.err_clr) begin
                r_err_h <= 1'b0;
            end
            if (w_set_v) begin
                r_err_v <= 1'b1;
            end else if (bus.err_clr) begin
                r_err_v <= 1'b0;
            end
        end
    end

    assign bus.locked      = r_locked;
    assign bus.active      = r_active;
    assign bus.col_addr    = r_col_addr;
    assign bus.row_addr    = r_row_addr;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_cnt   = r_frame_cnt;
    assign bus.err_h       = r_err_h;
    assign bus.err_v       = r_err_v;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 16x8 timing:
// hs low 2 samples, visible columns 4..13; vs low 1 line, visible rows 2..6.
module tb_vga_sync_decoder;

    localparam int H_TOT  = 16;
    localparam int V_TOT  = 8;
    localparam int HS_W   = 2;
    localparam int VS_W   = 1;
    localparam int FRAME  = H_TOT * V_TOT;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;
    int   gap;
    int   fsCount;
    logic vsMask;
    logic clrOnSample;

    vga_sync_decoder_if bus ();

    vga_sync_decoder #(
        .H_TOTAL     (H_TOT),
        .H_VIS_START (4),
        .H_VIS       (10),
        .V_TOTAL     (V_TOT),
        .V_VIS_START (2),
        .V_VIS       (5)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Count every CLK on which frame_start is seen high.
    always @(negedge CLK) begin
        if (bus.frame_start === 1'b1) fsCount++;
    end

    // Drive count samples starting at frame position fromIdx, one every gap CLKs;
    // returns on the negedge right after the last sample edge.
    task automatic genSamples(input int fromIdx, input int count);
        for (int n = 0; n < count; n++) begin
            int s;
            s = (fromIdx + n) % FRAME;
            repeat (gap - 1) @(negedge CLK);
            bus.pix_en  = 1'b1;
            bus.hs      = ((s % H_TOT) < HS_W) ? 1'b0 : 1'b1;
            bus.vs      = (((s / H_TOT) < VS_W) && !vsMask) ? 1'b0 : 1'b1;
            bus.err_clr = clrOnSample;
            @(negedge CLK);
            bus.pix_en  = 1'b0;
            bus.err_clr = 1'b0;
        end
    endtask

    // One CLK of reset with every other control asserted against it.
    task automatic applyReset();
        @(negedge CLK);
        RST = 1'b1; bus.pix_en = 1'b1; bus.err_clr = 1'b1; bus.hs = 1'b0; bus.vs = 1'b0;
        @(negedge CLK);
        RST = 1'b0; bus.pix_en = 1'b0; bus.err_clr = 1'b0; bus.hs = 1'b1; bus.vs = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        checks += 8;
        if (bus.locked !== 1'b0)      begin errors++; $display("[TB] FAIL reset_locked: got %b want 0", bus.locked); end
        if (bus.active !== 1'b0)      begin errors++; $display("[TB] FAIL reset_active: got %b want 0", bus.active); end
        if (bus.frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_fs: got %b want 0", bus.frame_start); end
        if (bus.frame_cnt !== 8'd0)   begin errors++; $display("[TB] FAIL reset_fcnt: got %0d want 0", bus.frame_cnt); end
        if (bus.err_h !== 1'b0)       begin errors++; $display("[TB] FAIL reset_err_h: got %b want 0", bus.err_h); end
        if (bus.err_v !== 1'b0)       begin errors++; $display("[TB] FAIL reset_err_v: got %b want 0", bus.err_v); end
        if (bus.col_addr !== 10'd0)   begin errors++; $display("[TB] FAIL reset_col: got %0d want 0", bus.col_addr); end
        if (bus.row_addr !== 9'd0)    begin errors++; $display("[TB] FAIL reset_row: got %0d want 0", bus.row_addr); end
    endtask

    task automatic test_nominal_lock();
        int fs0;
        fs0 = fsCount;
        genSamples(0, FRAME);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_early: got %b want 0", bus.locked); end
        genSamples(0, 1);
        checks += 4;
        if (bus.locked !== 1'b1)      begin errors++; $display("[TB] FAIL lock_locked: got %b want 1", bus.locked); end
        if (bus.frame_start !== 1'b1) begin errors++; $display("[TB] FAIL lock_fs: got %b want 1", bus.frame_start); end
        if (bus.frame_cnt !== 8'd1)   begin errors++; $display("[TB] FAIL lock_fcnt: got %0d want 1", bus.frame_cnt); end
        if (bus.active !== 1'b0)      begin errors++; $display("[TB] FAIL lock_active: got %b want 0", bus.active); end
        genSamples(1, 1);
        checks++;
        if (fsCount - fs0 !== 1) begin errors++; $display("[TB] FAIL lock_fs_count: got %0d want 1", fsCount - fs0); end
    endtask

    task automatic test_visible_window();
        genSamples(2, 35);
        checks += 3;
        if (bus.active !== 1'b1)    begin errors++; $display("[TB] FAIL win_first_active: got %b want 1", bus.active); end
        if (bus.col_addr !== 10'd0) begin errors++; $display("[TB] FAIL win_first_col: got %0d want 0", bus.col_addr); end
        if (bus.row_addr !== 9'd0)  begin errors++; $display("[TB] FAIL win_first_row: got %0d want 0", bus.row_addr); end
        genSamples(37, 73);
        checks += 3;
        if (bus.active !== 1'b1)    begin errors++; $display("[TB] FAIL win_last_active: got %b want 1", bus.active); end
        if (bus.col_addr !== 10'd9) begin errors++; $display("[TB] FAIL win_last_col: got %0d want 9", bus.col_addr); end
        if (bus.row_addr !== 9'd4)  begin errors++; $display("[TB] FAIL win_last_row: got %0d want 4", bus.row_addr); end
        genSamples(110, 1);
        checks += 2;
        if (bus.active !== 1'b0)    begin errors++; $display("[TB] FAIL win_past_active: got %b want 0", bus.active); end
        if (bus.col_addr !== 10'd0) begin errors++; $display("[TB] FAIL win_past_col: got %0d want 0", bus.col_addr); end
        genSamples(111, 17);
    endtask

    task automatic test_short_line();
        genSamples(0, H_TOT);
        genSamples(H_TOT, H_TOT - 1);
        genSamples(2 * H_TOT, 1);
        checks += 3;
        if (bus.err_h !== 1'b1)  begin errors++; $display("[TB] FAIL short_err_h: got %b want 1", bus.err_h); end
        if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL short_locked: got %b want 0", bus.locked); end
        if (bus.err_v !== 1'b0)  begin errors++; $display("[TB] FAIL short_err_v: got %b want 0", bus.err_v); end
        genSamples(2 * H_TOT + 1, FRAME - 2 * H_TOT - 1);
        genSamples(0, FRAME);
        genSamples(0, 1);
        checks += 3;
        if (bus.locked !== 1'b1)    begin errors++; $display("[TB] FAIL relock_locked: got %b want 1", bus.locked); end
        if (bus.err_h !== 1'b1)     begin errors++; $display("[TB] FAIL relock_err_h: got %b want 1", bus.err_h); end
        if (bus.frame_cnt !== 8'd3) begin errors++; $display("[TB] FAIL relock_fcnt: got %0d want 3", bus.frame_cnt); end
    endtask

    task automatic test_vs_withheld();
        genSamples(1, FRAME - 1);
        checks++;
        if (bus.err_v !== 1'b0) begin errors++; $display("[TB] FAIL vs_pre_err_v: got %b want 0", bus.err_v); end
        vsMask = 1'b1;
        genSamples(0, 1);
        vsMask = 1'b0;
        checks += 3;
        if (bus.err_v !== 1'b1)     begin errors++; $display("[TB] FAIL vs_err_v: got %b want 1", bus.err_v); end
        if (bus.locked !== 1'b0)    begin errors++; $display("[TB] FAIL vs_locked: got %b want 0", bus.locked); end
        if (bus.frame_cnt !== 8'd3) begin errors++; $display("[TB] FAIL vs_fcnt: got %0d want 3", bus.frame_cnt); end
    endtask

    task automatic test_err_clr();
        genSamples(1, FRAME - 1);
        genSamples(0, FRAME);
        genSamples(0, 1);
        checks++;
        if (bus.locked !== 1'b1) begin errors++; $display("[TB] FAIL clr_relock: got %b want 1", bus.locked); end
        genSamples(1, FRAME - 1);
        vsMask      = 1'b1;
        clrOnSample = 1'b1;
        genSamples(0, 1);
        vsMask      = 1'b0;
        clrOnSample = 1'b0;
        checks += 2;
        if (bus.err_v !== 1'b1) begin errors++; $display("[TB] FAIL clr_race_err_v: got %b want 1", bus.err_v); end
        if (bus.err_h !== 1'b0) begin errors++; $display("[TB] FAIL clr_race_err_h: got %b want 0", bus.err_h); end
        bus.err_clr = 1'b1;
        @(negedge CLK);
        bus.err_clr = 1'b0;
        checks += 2;
        if (bus.err_h !== 1'b0) begin errors++; $display("[TB] FAIL clr_err_h: got %b want 0", bus.err_h); end
        if (bus.err_v !== 1'b0) begin errors++; $display("[TB] FAIL clr_err_v: got %b want 0", bus.err_v); end
    endtask

    task automatic test_frame_wrap();
        gap = 1;
        applyReset();
        genSamples(0, FRAME);
        genSamples(0, FRAME * 254 + 1);
        checks += 2;
        if (bus.frame_cnt !== 8'd255) begin errors++; $display("[TB] FAIL wrap_255: got %0d want 255", bus.frame_cnt); end
        if (bus.frame_start !== 1'b1) begin errors++; $display("[TB] FAIL wrap_fs: got %b want 1", bus.frame_start); end
        genSamples(1, FRAME);
        checks += 2;
        if (bus.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL wrap_0: got %0d want 0", bus.frame_cnt); end
        if (bus.locked !== 1'b1)    begin errors++; $display("[TB] FAIL wrap_locked: got %b want 1", bus.locked); end
    endtask

    task automatic test_reset_mid_frame();
        genSamples(1, 40);
        checks += 2;
        if (bus.active !== 1'b1)    begin errors++; $display("[TB] FAIL mid_pre_active: got %b want 1", bus.active); end
        if (bus.col_addr !== 10'd4) begin errors++; $display("[TB] FAIL mid_pre_col: got %0d want 4", bus.col_addr); end
        applyReset();
        checks += 4;
        if (bus.locked !== 1'b0)    begin errors++; $display("[TB] FAIL mid_locked: got %b want 0", bus.locked); end
        if (bus.active !== 1'b0)    begin errors++; $display("[TB] FAIL mid_active: got %b want 0", bus.active); end
        if (bus.col_addr !== 10'd0) begin errors++; $display("[TB] FAIL mid_col: got %0d want 0", bus.col_addr); end
        if (bus.frame_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_fcnt: got %0d want 0", bus.frame_cnt); end
        genSamples(41, FRAME - 41);
        genSamples(0, 1);
        checks++;
        if (bus.locked !== 1'b0) begin errors++; $display("[TB] FAIL mid_no_fast_lock: got %b want 0", bus.locked); end
        genSamples(1, FRAME - 1);
        genSamples(0, 1);
        checks += 2;
        if (bus.locked !== 1'b1)    begin errors++; $display("[TB] FAIL mid_relock: got %b want 1", bus.locked); end
        if (bus.frame_cnt !== 8'd1) begin errors++; $display("[TB] FAIL mid_relock_fcnt: got %0d want 1", bus.frame_cnt); end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        fsCount     = 0;
        gap         = 4;
        vsMask      = 1'b0;
        clrOnSample = 1'b0;
        RST         = 1'b0;
        bus.pix_en  = 1'b0;
        bus.hs      = 1'b1;
        bus.vs      = 1'b1;
        bus.err_clr = 1'b0;
        $display("[TB] starting vga_sync_decoder bench");
        test_reset();
        test_nominal_lock();
        test_visible_window();
        test_short_line();
        test_vs_withheld();
        test_err_clr();
        test_frame_wrap();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 H_TOTAL, default 800, pixel samples per line.
REQ-002 H_VIS_START, default 144, first visible hcnt, covering 96 hsync plus 48 back porch.
REQ-003 V_TOTAL, default 525, lines per frame.
REQ-004 V_VIS_START, default 35, first visible vcnt, covering 2 vsync plus 33 back porch.
REQ-005 CLK  input  1  system clock; the only clock.
REQ-006 RST  input  1  reset; synchronous, active-high.
REQ-007 pix_en  input  1  pixel-sample enable; hs/vs are evaluated only on CLK edges where pix_en=1.
REQ-008 hs  input  1  horizontal sync, active-low.
REQ-009 vs  input  1  vertical sync, active-low.
REQ-010 err_clr  input  1  clears the sticky error flags.
REQ-011 row_addr  output  9  recovered visible row, 0..479.
REQ-012 col_addr  output  10  recovered visible column, 0..639.
REQ-013 active  output  1  recovered position is inside the visible window while locked.
REQ-014 locked  output  1  decoder is in the LOCKED state.
REQ-015 frame_start  output  1  one-CLK pulse at each locked vs falling edge.
REQ-016 frame_cnt  output  8  count of locked frames.
REQ-017 err_h  output  1  sticky flag: line-length violation.
REQ-018 err_v  output  1  sticky flag: frame-length violation.

Function
REQ-019 A sample SHALL be a CLK edge with pix_en=1; all state SHALL hold when pix_en=0.
REQ-020 An hs fall SHALL be a sample where registered hs_prev=1 and hs=0; a vs fall is defined identically using vs_prev.
REQ-021 hcnt (10 bit) SHALL load 0 on hs fall, otherwise increment per sample, saturating at 1023.
REQ-022 vcnt (10 bit) SHALL update only on hs fall: load 0 if vs=0 and vs_prev_line=1, otherwise increment, saturating at 1023.
REQ-023 The states SHALL be SEARCH, TRACK and LOCKED.
REQ-024 SEARCH -> TRACK SHALL occur on the first vs fall detected at an hs fall.
REQ-025 TRACK -> LOCKED SHALL occur at the next vs fall if every hs fall since entry arrived at hcnt=H_TOTAL-1 and the vs fall arrived at vcnt=V_TOTAL-1.
REQ-026 If the TRACK check in REQ-025 fails, TRACK -> SEARCH SHALL occur with no error flag set.
REQ-027 A horizontal violation in LOCKED SHALL be either an hs fall with hcnt != H_TOTAL-1, or hcnt reaching H_TOTAL.
REQ-028 A horizontal violation in LOCKED SHALL set err_h and move to SEARCH.
REQ-029 A vertical violation in LOCKED SHALL be either a vs fall with vcnt != V_TOTAL-1, or vcnt reaching V_TOTAL.
REQ-030 A vertical violation in LOCKED SHALL set err_v and move to SEARCH.
REQ-031 If horizontal and vertical violations occur in the same sample, both err_h and err_v SHALL set.
REQ-032 active SHALL be 1 only when locked and H_VIS_START <= hcnt < H_VIS_START+640 and V_VIS_START <= vcnt < V_VIS_START+480.
REQ-033 col_addr SHALL be hcnt-H_VIS_START and row_addr SHALL be vcnt-V_VIS_START while active, otherwise 0.
REQ-034 All outputs SHALL be registered, with a latency of 1 CLK after the deciding sample.
REQ-035 frame_start SHALL pulse for exactly 1 CLK on each vs fall accepted in LOCKED, including the TRACK -> LOCKED edge.
REQ-036 frame_cnt SHALL increment on each frame_start and wrap from 255 to 0.
REQ-037 err_clr SHALL clear err_h and err_v.
REQ-038 A new violation in the same cycle as err_clr SHALL win, leaving its flag set.
REQ-039 locked SHALL be 1 exactly in LOCKED.

Reset
REQ-040 RST=1 SHALL force, on the next CLK edge: SEARCH state; hcnt, vcnt, row_addr, col_addr, frame_cnt = 0; active, locked, frame_start, err_h, err_v = 0; hs_prev and vs_prev = 1.
REQ-041 RST SHALL override pix_en and err_clr.
REQ-042 RST asserted mid-frame SHALL discard the current lock, requiring a new SEARCH -> TRACK -> LOCKED sequence.

Verification
REQ-043 Nominal 640x480 timing (pix_en every 4th CLK, from reset) -> locked=1 after the second vs fall; frame_start pulses once; frame_cnt=1.
REQ-044 Locked; sample at hcnt=144, vcnt=35 -> active=1, col_addr=0, row_addr=0; at hcnt=783, vcnt=514 -> col_addr=639, row_addr=479; at hcnt=784 -> active=0, col_addr=0.
REQ-045 Locked; one line shortened to 799 samples -> err_h=1, locked=0 one CLK after that hs fall; re-lock after 2 clean frames; err_h stays 1.
REQ-046 Locked; vs withheld -> err_v=1 when vcnt reaches 525; frame_cnt frozen.
REQ-047 err_clr pulsed in the same cycle as a new vs violation -> err_v remains 1; err_clr alone -> err_h=0, err_v=0.
REQ-048 256 locked frames -> frame_cnt wraps to 0; RST mid-line -> all outputs 0 next CLK.
